// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared types, constants and address decode for the SRAM/UART bridge
package bridge_pkg;

    typedef enum logic [1:0] {TGT_BASE, TGT_EXT, TGT_UART, TGT_NONE} target_e;
    typedef enum logic [1:0] {CH_IDLE, CH_ACC, CH_DONE} chan_state_e;

    localparam logic [31:0] DEADBEEF      = 32'hDEAD_BEEF;
    localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;

    // With aliasing on, bit 31 is forced so low-half images land in the same SRAM window.
    function automatic target_e decode(input logic [31:0] addr, input logic is_lsu,
                                       input logic [31:0] base_addr, input logic [31:0] ext_addr,
                                       input logic [31:0] uart_addr, input logic sim_alias);
        logic [9:0] win;
        win = sim_alias ? {1'b1, addr[30:22]} : addr[31:22];
        if (win == base_addr[31:22])
            decode = TGT_BASE;
        else if (win == ext_addr[31:22])
            decode = TGT_EXT;
        else if (is_lsu && (addr == uart_addr + UART_DATA_OFS || addr == uart_addr + UART_STAT_OFS))
            decode = TGT_UART;
        else
            decode = TGT_NONE;
    endfunction

endpackage

// File: rtl/sram_chan.sv
// rtl/sram_chan.sv - one SRAM channel: IFU/LSU round-robin arbiter, wait-state FSM and pin drive
module sram_chan
    import bridge_pkg::*;
#(
    parameter int RAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_want_i,
    input  logic        lsu_want_i,
    input  logic [19:0] ifu_addr_i,
    input  logic [19:0] lsu_addr_i,
    input  logic [31:0] ifu_wdata_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  ifu_be_n_i,
    input  logic [3:0]  lsu_be_n_i,
    input  logic        ifu_we_n_i,
    input  logic        lsu_we_n_i,
    input  logic [31:0] ram_rdata_i,
    output logic [31:0] ram_wdata_o,
    output logic [19:0] ram_addr_o,
    output logic [3:0]  ram_be_n_o,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o,
    output logic        ifu_own_o,
    output logic        lsu_own_o,
    output logic        ifu_resp_o,
    output logic        lsu_resp_o,
    output logic [31:0] rdata_o
);

    localparam int CW = $clog2(RAM_WAIT + 1);

    chan_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic        owner_lsu_q, prio_lsu_q, write_q;
    logic [19:0] addr_q;
    logic [3:0]  be_n_q;
    logic [31:0] wdata_q, rdata_q;
    logic        grant_lsu, last_phase;

    assign grant_lsu  = lsu_want_i && (!ifu_want_i || prio_lsu_q);
    assign last_phase = (cnt_q == CW'(RAM_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CH_IDLE;
            cnt_q       <= '0;
            owner_lsu_q <= 1'b0;
            prio_lsu_q  <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            be_n_q      <= 4'hF;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    if (ifu_want_i || lsu_want_i) begin
                        state_q     <= CH_ACC;
                        cnt_q       <= '0;
                        owner_lsu_q <= grant_lsu;
                        // Priority only flips on a contended grant so a loser keeps its turn.
                        if (ifu_want_i && lsu_want_i)
                            prio_lsu_q <= !grant_lsu;
                        write_q <= grant_lsu ? !lsu_we_n_i : !ifu_we_n_i;
                        addr_q  <= grant_lsu ? lsu_addr_i  : ifu_addr_i;
                        be_n_q  <= grant_lsu ? lsu_be_n_i  : ifu_be_n_i;
                        wdata_q <= grant_lsu ? lsu_wdata_i : ifu_wdata_i;
                    end
                end
                CH_ACC: begin
                    if (last_phase) begin
                        state_q <= CH_DONE;
                        rdata_q <= write_q ? 32'd0 : ram_rdata_i;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CH_DONE: state_q <= CH_IDLE;
                default: state_q <= CH_IDLE;
            endcase
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_be_n_o  = be_n_q;
    assign ram_wdata_o = wdata_q;
    assign ram_ce_n_o  = !(state_q == CH_ACC);
    assign ram_oe_n_o  = !(state_q == CH_ACC && !write_q);
    // we_n rises one phase early to give the SRAM write hold time on address/data.
    assign ram_we_n_o  = !(state_q == CH_ACC && write_q && !last_phase);

    assign ifu_own_o  = (state_q != CH_IDLE) && !owner_lsu_q;
    assign lsu_own_o  = (state_q != CH_IDLE) && owner_lsu_q;
    assign ifu_resp_o = (state_q == CH_DONE) && !owner_lsu_q;
    assign lsu_resp_o = (state_q == CH_DONE) && owner_lsu_q;
    assign rdata_o    = rdata_q;

endmodule

// File: rtl/sram_uart_bridge_arb.sv
// rtl/sram_uart_bridge_arb.sv - registered IFU/LSU bridge to BaseRAM, ExtRAM and a FIFO-buffered UART
module sram_uart_bridge_arb
    import bridge_pkg::*;
#(
    parameter int          RAM_WAIT  = 2,
    parameter int          TXQ_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] EXT_ADDR  = 32'h8040_0000,
    parameter logic [31:0] UART_ADDR = 32'hBFD0_03F8,
    parameter bit          SIM_ALIAS = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_addr_i,
    input  logic [31:0] ifu_wdata_i,
    input  logic [3:0]  ifu_be_n_i,
    input  logic        ifu_re_n_i,
    input  logic        ifu_we_n_i,
    input  logic        ifu_req_i,
    output logic        ifu_resp_o,
    output logic [31:0] ifu_rdata_o,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_be_n_i,
    input  logic        lsu_re_n_i,
    input  logic        lsu_we_n_i,
    input  logic        lsu_req_i,
    output logic        lsu_resp_o,
    output logic [31:0] lsu_rdata_o,
    output logic [31:0] base_ram_wdata,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    input  logic [31:0] base_ram_rdata,
    output logic [31:0] ext_ram_wdata,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n,
    input  logic [31:0] ext_ram_rdata,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_ready,
    input  logic [7:0]  uart_rx_data_i,
    output logic        uart_we_n_o,
    output logic        uart_re_n_o,
    output logic [7:0]  uart_tx_data_o
);

    localparam int AW = $clog2(TXQ_DEPTH);

    target_e ifu_tgt, lsu_tgt;
    logic ifu_act, lsu_act;
    logic base_ifu_own, base_lsu_own, ext_ifu_own, ext_lsu_own;
    logic base_ifu_resp, base_lsu_resp, ext_ifu_resp, ext_lsu_resp;
    logic [31:0] base_rdata, ext_rdata;

    assign ifu_act = ifu_req_i && (!ifu_re_n_i || !ifu_we_n_i);
    assign lsu_act = lsu_req_i && (!lsu_re_n_i || !lsu_we_n_i);
    assign ifu_tgt = decode(ifu_addr_i, 1'b0, BASE_ADDR, EXT_ADDR, UART_ADDR, SIM_ALIAS);
    assign lsu_tgt = decode(lsu_addr_i, 1'b1, BASE_ADDR, EXT_ADDR, UART_ADDR, SIM_ALIAS);

    sram_chan #(.RAM_WAIT(RAM_WAIT)) u_base (
        .clk(clk), .rst(rst),
        .ifu_want_i(ifu_act && ifu_tgt == TGT_BASE && !ext_ifu_own),
        .lsu_want_i(lsu_act && lsu_tgt == TGT_BASE && !ext_lsu_own),
        .ifu_addr_i(ifu_addr_i[21:2]), .lsu_addr_i(lsu_addr_i[21:2]),
        .ifu_wdata_i(ifu_wdata_i), .lsu_wdata_i(lsu_wdata_i),
        .ifu_be_n_i(ifu_be_n_i), .lsu_be_n_i(lsu_be_n_i),
        .ifu_we_n_i(ifu_we_n_i), .lsu_we_n_i(lsu_we_n_i),
        .ram_rdata_i(base_ram_rdata),
        .ram_wdata_o(base_ram_wdata), .ram_addr_o(base_ram_addr), .ram_be_n_o(base_ram_be_n),
        .ram_ce_n_o(base_ram_ce_n), .ram_oe_n_o(base_ram_oe_n), .ram_we_n_o(base_ram_we_n),
        .ifu_own_o(base_ifu_own), .lsu_own_o(base_lsu_own),
        .ifu_resp_o(base_ifu_resp), .lsu_resp_o(base_lsu_resp), .rdata_o(base_rdata)
    );

    sram_chan #(.RAM_WAIT(RAM_WAIT)) u_ext (
        .clk(clk), .rst(rst),
        .ifu_want_i(ifu_act && ifu_tgt == TGT_EXT && !base_ifu_own),
        .lsu_want_i(lsu_act && lsu_tgt == TGT_EXT && !base_lsu_own),
        .ifu_addr_i(ifu_addr_i[21:2]), .lsu_addr_i(lsu_addr_i[21:2]),
        .ifu_wdata_i(ifu_wdata_i), .lsu_wdata_i(lsu_wdata_i),
        .ifu_be_n_i(ifu_be_n_i), .lsu_be_n_i(lsu_be_n_i),
        .ifu_we_n_i(ifu_we_n_i), .lsu_we_n_i(lsu_we_n_i),
        .ram_rdata_i(ext_ram_rdata),
        .ram_wdata_o(ext_ram_wdata), .ram_addr_o(ext_ram_addr), .ram_be_n_o(ext_ram_be_n),
        .ram_ce_n_o(ext_ram_ce_n), .ram_oe_n_o(ext_ram_oe_n), .ram_we_n_o(ext_ram_we_n),
        .ifu_own_o(ext_ifu_own), .lsu_own_o(ext_lsu_own),
        .ifu_resp_o(ext_ifu_resp), .lsu_resp_o(ext_lsu_resp), .rdata_o(ext_rdata)
    );

    logic [7:0]  txq_mem [TXQ_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_full, fifo_empty, push, pop, gap_q, uart_we_n_q;
    logic [7:0]  tx_data_q;
    logic        lsu_misc_go, lsu_uart_data, rd_pend_q, lsu_misc_resp_q, ifu_none_resp_q;
    logic [31:0] lsu_misc_rdata_q;

    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign pop        = !fifo_empty && uart_tx_ready && !gap_q;

    // The misc path is blocked while a response or a pending RX read is in flight, so a held req fires once.
    assign lsu_misc_go   = lsu_act && (lsu_tgt == TGT_UART || lsu_tgt == TGT_NONE)
                           && !lsu_misc_resp_q && !rd_pend_q;
    assign lsu_uart_data = (lsu_addr_i == UART_ADDR + UART_DATA_OFS);
    assign push          = lsu_misc_go && lsu_tgt == TGT_UART && lsu_uart_data && !lsu_we_n_i
                           && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push)
            txq_mem[wr_ptr_q[AW-1:0]] <= lsu_wdata_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            gap_q       <= 1'b0;
            uart_we_n_q <= 1'b1;
            tx_data_q   <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            gap_q       <= pop;
            uart_we_n_q <= !pop;
            if (pop) begin
                tx_data_q <= txq_mem[rd_ptr_q[AW-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_misc_resp_q  <= 1'b0;
            lsu_misc_rdata_q <= '0;
            rd_pend_q        <= 1'b0;
            ifu_none_resp_q  <= 1'b0;
        end else begin
            lsu_misc_resp_q <= 1'b0;
            rd_pend_q       <= 1'b0;
            ifu_none_resp_q <= ifu_act && ifu_tgt == TGT_NONE && !ifu_none_resp_q;
            if (rd_pend_q) begin
                lsu_misc_resp_q  <= 1'b1;
                lsu_misc_rdata_q <= {24'd0, uart_rx_data_i};
            end else if (lsu_misc_go) begin
                if (lsu_tgt == TGT_NONE) begin
                    lsu_misc_resp_q  <= 1'b1;
                    lsu_misc_rdata_q <= DEADBEEF;
                end else if (lsu_uart_data && !lsu_we_n_i) begin
                    lsu_misc_resp_q  <= push;
                    lsu_misc_rdata_q <= 32'd0;
                end else if (lsu_uart_data) begin
                    rd_pend_q <= 1'b1;
                end else if (!lsu_we_n_i) begin
                    lsu_misc_resp_q  <= 1'b1;
                    lsu_misc_rdata_q <= 32'd0;
                end else begin
                    lsu_misc_resp_q  <= 1'b1;
                    lsu_misc_rdata_q <= {30'd0, uart_rx_ready, !fifo_full};
                end
            end
        end
    end

    assign uart_re_n_o    = !rd_pend_q;
    assign uart_we_n_o    = uart_we_n_q;
    assign uart_tx_data_o = tx_data_q;

    assign ifu_resp_o  = base_ifu_resp | ext_ifu_resp | ifu_none_resp_q;
    assign ifu_rdata_o = base_ifu_resp ? base_rdata :
                         ext_ifu_resp  ? ext_rdata  :
                         ifu_none_resp_q ? DEADBEEF : 32'd0;
    assign lsu_resp_o  = base_lsu_resp | ext_lsu_resp | lsu_misc_resp_q;
    assign lsu_rdata_o = base_lsu_resp ? base_rdata :
                         ext_lsu_resp  ? ext_rdata  :
                         lsu_misc_resp_q ? lsu_misc_rdata_q : 32'd0;

endmodule

// File: tb/tb_sram_uart_bridge_arb.sv
// tb/tb_sram_uart_bridge_arb.sv - directed vector bench for sram_uart_bridge_arb
module tb_sram_uart_bridge_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_addr_i = '0, ifu_wdata_i = '0, lsu_addr_i = '0, lsu_wdata_i = '0;
    logic [3:0]  ifu_be_n_i = 4'hF, lsu_be_n_i = 4'hF;
    logic        ifu_re_n_i = 1'b1, ifu_we_n_i = 1'b1, ifu_req_i = 1'b0;
    logic        lsu_re_n_i = 1'b1, lsu_we_n_i = 1'b1, lsu_req_i = 1'b0;
    logic        ifu_resp_o, lsu_resp_o;
    logic [31:0] ifu_rdata_o, lsu_rdata_o;
    logic [31:0] base_ram_wdata, ext_ram_wdata, base_ram_rdata, ext_ram_rdata;
    logic [19:0] base_ram_addr, ext_ram_addr;
    logic [3:0]  base_ram_be_n, ext_ram_be_n;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
    logic        uart_tx_ready = 1'b0, uart_rx_ready = 1'b1;
    logic [7:0]  uart_rx_data_i = 8'h5A;
    logic        uart_we_n_o, uart_re_n_o;
    logic [7:0]  uart_tx_data_o;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Read-only SRAM models: data is a tag plus the word address presented on the pins.
    assign base_ram_rdata = {12'hBA5, base_ram_addr};
    assign ext_ram_rdata  = {12'hE87, ext_ram_addr};

    sram_uart_bridge_arb #(
        .RAM_WAIT(2), .TXQ_DEPTH(4), .BASE_ADDR(32'h8000_0000), .EXT_ADDR(32'h8040_0000),
        .UART_ADDR(32'hBFD0_03F8), .SIM_ALIAS(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_addr_i(ifu_addr_i), .ifu_wdata_i(ifu_wdata_i), .ifu_be_n_i(ifu_be_n_i),
        .ifu_re_n_i(ifu_re_n_i), .ifu_we_n_i(ifu_we_n_i), .ifu_req_i(ifu_req_i),
        .ifu_resp_o(ifu_resp_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_be_n_i(lsu_be_n_i),
        .lsu_re_n_i(lsu_re_n_i), .lsu_we_n_i(lsu_we_n_i), .lsu_req_i(lsu_req_i),
        .lsu_resp_o(lsu_resp_o), .lsu_rdata_o(lsu_rdata_o),
        .base_ram_wdata(base_ram_wdata), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
        .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .base_ram_rdata(base_ram_rdata),
        .ext_ram_wdata(ext_ram_wdata), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
        .ext_ram_rdata(ext_ram_rdata),
        .uart_tx_ready(uart_tx_ready), .uart_rx_ready(uart_rx_ready), .uart_rx_data_i(uart_rx_data_i),
        .uart_we_n_o(uart_we_n_o), .uart_re_n_o(uart_re_n_o), .uart_tx_data_o(uart_tx_data_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lsu, input logic [31:0] addr, input logic wr,
                         input logic [3:0] be_n, input logic [31:0] wdata);
        if (lsu) begin
            lsu_addr_i = addr; lsu_we_n_i = !wr; lsu_re_n_i = wr;
            lsu_be_n_i = be_n; lsu_wdata_i = wdata; lsu_req_i = 1'b1;
        end else begin
            ifu_addr_i = addr; ifu_we_n_i = !wr; ifu_re_n_i = wr;
            ifu_be_n_i = be_n; ifu_wdata_i = wdata; ifu_req_i = 1'b1;
        end
    endtask

    task automatic do_req(input string name, input logic lsu, input logic [31:0] addr, input logic wr,
                          input logic [3:0] be_n, input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input int exp_ce, input int exp_we);
        int lat = 0, ce = 0, we = 0;
        logic [31:0] rd = '0;
        drive(lsu, addr, wr, be_n, wdata);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (!base_ram_ce_n || !ext_ram_ce_n) ce++;
            if (!base_ram_we_n || !ext_ram_we_n) we++;
            if (lsu ? lsu_resp_o : ifu_resp_o) begin
                lat = c;
                rd  = lsu ? lsu_rdata_o : ifu_rdata_o;
            end
        end
        ifu_req_i = 1'b0;
        lsu_req_i = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_rdata"}, rd, exp_rdata);
        check({name, "_ce_cycles"}, ce, exp_ce);
        check({name, "_we_cycles"}, we, exp_we);
        tick();
    endtask

    task automatic dual(input string name, input logic [31:0] ia, input logic [31:0] la, input logic lw,
                        input logic [3:0] lbe, input logic [31:0] lwd, input int exp_ic, input int exp_lc,
                        input logic [31:0] exp_ir, input logic [31:0] exp_lr, input int exp_both,
                        input int exp_extwe, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int ic = 0, lc = 0, both = 0, extwe = 0;
        logic [31:0] ir = '0, lr = '0, wd = '0;
        logic [3:0] be = 4'hF;
        drive(1'b0, ia, 1'b0, 4'h0, 32'd0);
        drive(1'b1, la, lw, lbe, lwd);
        for (int c = 1; c <= 40 && (ic == 0 || lc == 0); c++) begin
            tick();
            if (!base_ram_ce_n && !ext_ram_ce_n) both++;
            if (!ext_ram_we_n) begin extwe++; be = ext_ram_be_n; wd = ext_ram_wdata; end
            if (ifu_resp_o && ic == 0) begin ic = c; ir = ifu_rdata_o; ifu_req_i = 1'b0; end
            if (lsu_resp_o && lc == 0) begin lc = c; lr = lsu_rdata_o; lsu_req_i = 1'b0; end
        end
        ifu_req_i = 1'b0;
        lsu_req_i = 1'b0;
        check({name, "_ifu_cycle"}, ic, exp_ic);
        check({name, "_lsu_cycle"}, lc, exp_lc);
        check({name, "_ifu_rdata"}, ir, exp_ir);
        check({name, "_lsu_rdata"}, lr, exp_lr);
        check({name, "_overlap"}, both, exp_both);
        check({name, "_ext_we_cycles"}, extwe, exp_extwe);
        check({name, "_ext_be_n"}, {28'd0, be}, {28'd0, exp_be});
        check({name, "_ext_wdata"}, wd, exp_wd);
        tick();
    endtask

    typedef struct {
        logic        lsu;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be_n;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          ce;
        int          we;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int stall_resp, r5, n_str, fifo_strobes, late_resp;
        int s_cyc[5];
        logic [7:0] s_dat[5];

        vecs[0]  = '{1'b0, 32'h8000_0010, 1'b0, 4'h0, 32'd0,          4, 32'hBA50_0004, 3, 0};
        vecs[1]  = '{1'b1, 32'h8040_0008, 1'b0, 4'h0, 32'd0,          4, 32'hE870_0002, 3, 0};
        vecs[2]  = '{1'b1, 32'h8000_0020, 1'b1, 4'h0, 32'h1234_5678,  4, 32'd0,         3, 2};
        vecs[3]  = '{1'b0, 32'h8040_0040, 1'b1, 4'h3, 32'h0BAD_F00D,  4, 32'd0,         3, 2};
        vecs[4]  = '{1'b1, 32'h1234_0000, 1'b0, 4'h0, 32'd0,          1, 32'hDEAD_BEEF, 0, 0};
        vecs[5]  = '{1'b0, 32'hBFD0_03F8, 1'b0, 4'h0, 32'd0,          1, 32'hDEAD_BEEF, 0, 0};
        vecs[6]  = '{1'b1, 32'hBFD0_03FC, 1'b0, 4'h0, 32'd0,          1, 32'h0000_0003, 0, 0};
        vecs[7]  = '{1'b1, 32'hBFD0_03F8, 1'b0, 4'h0, 32'd0,          2, 32'h0000_005A, 0, 0};
        vecs[8]  = '{1'b1, 32'hBFD0_03FC, 1'b1, 4'h0, 32'h0000_00FF,  1, 32'd0,         0, 0};
        vecs[9]  = '{1'b0, 32'h803F_FFFC, 1'b0, 4'h0, 32'd0,          4, 32'hBA5F_FFFF, 3, 0};
        vecs[10] = '{1'b1, 32'h8080_0000, 1'b0, 4'h0, 32'd0,          1, 32'hDEAD_BEEF, 0, 0};
        vecs[11] = '{1'b1, 32'h0000_0010, 1'b0, 4'h0, 32'd0,          1, 32'hDEAD_BEEF, 0, 0};

        repeat (3) tick();
        check("rst_ifu_resp", {31'd0, ifu_resp_o}, 32'd0);
        check("rst_lsu_resp", {31'd0, lsu_resp_o}, 32'd0);
        check("rst_rdata", ifu_rdata_o | lsu_rdata_o, 32'd0);
        check("rst_base_strobes", {29'd0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n}, 32'h7);
        check("rst_ext_strobes", {29'd0, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h7);
        check("rst_be_n", {24'd0, base_ram_be_n, ext_ram_be_n}, 32'hFF);
        check("rst_addr", {12'd0, base_ram_addr | ext_ram_addr}, 32'd0);
        check("rst_wdata", base_ram_wdata | ext_ram_wdata, 32'd0);
        check("rst_uart", {22'd0, uart_we_n_o, uart_re_n_o, uart_tx_data_o}, 32'h300);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++)
            do_req($sformatf("vec%0d", i), vecs[i].lsu, vecs[i].addr, vecs[i].wr, vecs[i].be_n,
                   vecs[i].wdata, vecs[i].lat, vecs[i].rdata, vecs[i].ce, vecs[i].we);

        dual("rr1", 32'h8000_0100, 32'h8000_0200, 1'b0, 4'h0, 32'd0, 4, 9,
             32'hBA50_0040, 32'hBA50_0080, 0, 0, 4'hF, 32'd0);
        dual("rr2", 32'h8000_0100, 32'h8000_0200, 1'b0, 4'h0, 32'd0, 9, 4,
             32'hBA50_0040, 32'hBA50_0080, 0, 0, 4'hF, 32'd0);
        dual("conc", 32'h8000_0010, 32'h8040_0000, 1'b1, 4'b1110, 32'hCAFE_F00D, 4, 4,
             32'hBA50_0004, 32'd0, 3, 2, 4'b1110, 32'hCAFE_F00D);

        // UART TX queue: fill while the transmitter is busy, then watch the paced drain.
        for (int i = 0; i < 4; i++)
            do_req($sformatf("txw%0d", i), 1'b1, 32'hBFD0_03F8, 1'b1, 4'h0, 32'((i + 1) * 17),
                   1, 32'd0, 0, 0);
        do_req("status_full", 1'b1, 32'hBFD0_03FC, 1'b0, 4'h0, 32'd0, 1, 32'h0000_0002, 0, 0);
        drive(1'b1, 32'hBFD0_03F8, 1'b1, 4'h0, 32'h0000_0055);
        stall_resp = 0;
        fifo_strobes = 0;
        repeat (6) begin
            tick();
            if (lsu_resp_o) stall_resp++;
            if (!uart_we_n_o) fifo_strobes++;
        end
        check("txw_stall_resp", stall_resp, 0);
        check("txw_no_drain", fifo_strobes, 0);
        uart_tx_ready = 1'b1;
        r5 = 0;
        n_str = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (lsu_resp_o && r5 == 0) begin r5 = c; lsu_req_i = 1'b0; end
            if (!uart_we_n_o) begin
                if (n_str < 5) begin s_cyc[n_str] = c; s_dat[n_str] = uart_tx_data_o; end
                n_str++;
            end
        end
        lsu_req_i = 1'b0;
        check("txw5_resp_cycle", r5, 1);
        check("drain_count", n_str, 5);
        for (int i = 0; i < 5 && i < n_str; i++) begin
            check($sformatf("drain_data%0d", i), {24'd0, s_dat[i]}, 32'((i + 1) * 17));
            if (i > 0) check($sformatf("drain_gap%0d", i), s_cyc[i] - s_cyc[i - 1], 2);
        end
        do_req("status_empty", 1'b1, 32'hBFD0_03FC, 1'b0, 4'h0, 32'd0, 1, 32'h0000_0003, 0, 0);

        // Reset during the second access phase, with a byte parked in the queue.
        uart_tx_ready = 1'b0;
        do_req("txw_park", 1'b1, 32'hBFD0_03F8, 1'b1, 4'h0, 32'h0000_0066, 1, 32'd0, 0, 0);
        drive(1'b0, 32'h8000_0010, 1'b0, 4'h0, 32'd0);
        tick();
        tick();
        check("mid_ce_low", {31'd0, base_ram_ce_n}, 32'd0);
        rst = 1'b1;
        tick();
        check("abort_strobes", {29'd0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n}, 32'h7);
        check("abort_resp", {31'd0, ifu_resp_o}, 32'd0);
        ifu_req_i = 1'b0;
        rst = 1'b0;
        uart_tx_ready = 1'b1;
        late_resp = 0;
        fifo_strobes = 0;
        repeat (8) begin
            tick();
            if (ifu_resp_o) late_resp++;
            if (!uart_we_n_o) fifo_strobes++;
        end
        check("abort_no_late_resp", late_resp, 0);
        check("abort_fifo_empty", fifo_strobes, 0);
        do_req("post_rst", 1'b0, 32'h8000_0010, 1'b0, 4'h0, 32'd0, 4, 32'hBA50_0004, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
